// File: rtl/clique_report_arbiter_if.sv
// Requester/report bus of clique_report_arbiter.
// slave = arbiter side; master = requesters plus downstream consumer.
`ifndef MAX_CLIQUESIZEBITS
`define MAX_CLIQUESIZEBITS 8
`endif

interface clique_report_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int SRC_BITS = 2
);
    localparam int SB = `MAX_CLIQUESIZEBITS;

    logic [NUM_REQ*16-1:0] i_req_v;
    logic [NUM_REQ*SB-1:0] i_req_size;
    logic [NUM_REQ-1:0]    i_req_valid;
    logic [NUM_REQ-1:0]    i_req_strobe;
    logic [NUM_REQ-1:0]    i_req_last;
    logic [NUM_REQ-1:0]    o_req_accept;

    logic [15:0]           o_report_v;
    logic [SB-1:0]         o_report_size;
    logic [SRC_BITS-1:0]   o_report_src;
    logic                  o_report_valid;
    logic                  o_report_strobe;
    logic                  i_report_accept;

    logic [SB-1:0]         o_global_maxsize;
    logic                  o_busy;
    logic [7:0]            o_dropped;

    modport slave (
        input  i_req_v, i_req_size, i_req_valid, i_req_strobe, i_req_last, i_report_accept,
        output o_req_accept, o_report_v, o_report_size, o_report_src, o_report_valid,
        output o_report_strobe, o_global_maxsize, o_busy, o_dropped
    );

    modport master (
        output i_req_v, i_req_size, i_req_valid, i_req_strobe, i_req_last, i_report_accept,
        input  o_req_accept, o_report_v, o_report_size, o_report_src, o_report_valid,
        input  o_report_strobe, o_global_maxsize, o_busy, o_dropped
    );
endinterface

// File: rtl/clique_report_arbiter.sv
// Round-robin merge of clique_stack report bursts into one registered stream.
// Optional CLIQUE_ARB_FILTER_EN drops bursts smaller than the global max size.
`ifndef MAX_CLIQUESIZEBITS
`define MAX_CLIQUESIZEBITS 8
`endif

module clique_report_arbiter_lane #(
    parameter int SB = 8
) (
    input  logic          sel_i,
    input  logic          take_i,
    input  logic          valid_i,
    input  logic          strobe_i,
    input  logic          last_i,
    input  logic [15:0]   v_i,
    input  logic [SB-1:0] size_i,
    output logic          accept_o,
    output logic          strobe_o,
    output logic          last_o,
    output logic [15:0]   v_o,
    output logic [SB-1:0] size_o
);
    // Non-selected lanes output zeros so the top can OR-reduce instead of muxing.
    assign accept_o = sel_i && valid_i && take_i;
    assign strobe_o = sel_i && strobe_i;
    assign last_o   = sel_i && last_i;
    assign v_o      = sel_i ? v_i    : '0;
    assign size_o   = sel_i ? size_i : '0;
endmodule

module clique_report_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int SRC_BITS = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_sreset,
    clique_report_arbiter_if.slave bus
);
    localparam int SB = `MAX_CLIQUESIZEBITS;

`ifdef CLIQUE_ARB_FILTER_EN
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DROP} state_e;
`else
    typedef enum logic {S_IDLE, S_GRANT} state_e;
`endif

    state_e                state_q;
    logic [SRC_BITS-1:0]   gnt_q;
    logic [SRC_BITS-1:0]   rr_ptr_q;
    logic                  rpt_valid_q;
    logic                  rpt_strobe_q;
    logic [15:0]           rpt_v_q;
    logic [SB-1:0]         rpt_size_q;
    logic [SRC_BITS-1:0]   rpt_src_q;
    logic [SB-1:0]         maxsize_q, maxsize_d;

    logic                  out_load;
    logic                  take;
    logic                  fwd;
    logic                  acc_any;
    logic                  found;
    logic [SRC_BITS-1:0]   pick;

    logic [NUM_REQ-1:0]           sel;
    logic [NUM_REQ-1:0]           lane_acc;
    logic [NUM_REQ-1:0]           lane_strobe;
    logic [NUM_REQ-1:0]           lane_last;
    logic [NUM_REQ-1:0][15:0]     lane_v;
    logic [NUM_REQ-1:0][SB-1:0]   lane_size;

    logic                  mux_strobe;
    logic                  mux_last;
    logic [15:0]           mux_v;
    logic [SB-1:0]         mux_size;

    assign out_load = !rpt_valid_q || bus.i_report_accept;

    always_comb begin
        take = 1'b0;
        case (state_q)
            S_GRANT: take = out_load;
`ifdef CLIQUE_ARB_FILTER_EN
            // Dropped words never reach the output, so downstream backpressure is irrelevant.
            S_DROP:  take = 1'b1;
`endif
            default: take = 1'b0;
        endcase
    end

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
        assign sel[k] = (state_q != S_IDLE) && (gnt_q == SRC_BITS'(k));

        clique_report_arbiter_lane #(.SB(SB)) u_lane (
            .sel_i    (sel[k]),
            .take_i   (take),
            .valid_i  (bus.i_req_valid[k]),
            .strobe_i (bus.i_req_strobe[k]),
            .last_i   (bus.i_req_last[k]),
            .v_i      (bus.i_req_v[k*16 +: 16]),
            .size_i   (bus.i_req_size[k*SB +: SB]),
            .accept_o (lane_acc[k]),
            .strobe_o (lane_strobe[k]),
            .last_o   (lane_last[k]),
            .v_o      (lane_v[k]),
            .size_o   (lane_size[k])
        );
    end

    always_comb begin
        mux_v      = '0;
        mux_size   = '0;
        mux_strobe = 1'b0;
        mux_last   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            mux_v      = mux_v    | lane_v[k];
            mux_size   = mux_size | lane_size[k];
            mux_strobe = mux_strobe | lane_strobe[k];
            mux_last   = mux_last   | lane_last[k];
        end
    end

    assign acc_any = |lane_acc;
    assign fwd     = (state_q == S_GRANT) && acc_any;

    // Round-robin search starts one past the last completed requester.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!found && bus.i_req_valid[idx]) begin
                found = 1'b1;
                pick  = SRC_BITS'(idx);
            end
        end
    end

    always_comb begin
        maxsize_d = maxsize_q;
        if (fwd && mux_last && (mux_size > maxsize_q))
            maxsize_d = mux_size;
        if (i_sreset)
            maxsize_d = '0;
    end

`ifdef CLIQUE_ARB_FILTER_EN
    logic [SB-1:0] pick_size;
    logic [7:0]    dropped_q, dropped_d;

    assign pick_size = bus.i_req_size[int'(pick)*SB +: SB];

    always_comb begin
        dropped_d = dropped_q;
        if ((state_q == S_DROP) && acc_any && mux_last && (dropped_q != 8'hFF))
            dropped_d = dropped_q + 8'd1;
        if (i_sreset)
            dropped_d = '0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) dropped_q <= '0;
        else            dropped_q <= dropped_d;
    end

    assign bus.o_dropped = dropped_q;
`else
    assign bus.o_dropped = 8'd0;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            rr_ptr_q     <= SRC_BITS'(NUM_REQ - 1);
            rpt_valid_q  <= 1'b0;
            rpt_strobe_q <= 1'b0;
            rpt_v_q      <= '0;
            rpt_size_q   <= '0;
            rpt_src_q    <= '0;
            maxsize_q    <= '0;
        end else begin
            maxsize_q <= maxsize_d;

            if (out_load) begin
                rpt_valid_q  <= fwd;
                rpt_strobe_q <= fwd && mux_strobe;
                if (fwd) begin
                    rpt_v_q    <= mux_v;
                    rpt_size_q <= mux_size;
                    rpt_src_q  <= gnt_q;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        gnt_q <= pick;
`ifdef CLIQUE_ARB_FILTER_EN
                        state_q <= (pick_size < maxsize_q) ? S_DROP : S_GRANT;
`else
                        state_q <= S_GRANT;
`endif
                    end
                end
                default: begin
                    // Grant is held until the last word is consumed, whether forwarded or dropped.
                    if (acc_any && mux_last) begin
                        rr_ptr_q <= gnt_q;
                        state_q  <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.o_req_accept     = lane_acc;
    assign bus.o_report_v       = rpt_v_q;
    assign bus.o_report_size    = rpt_size_q;
    assign bus.o_report_src     = rpt_src_q;
    assign bus.o_report_valid   = rpt_valid_q;
    assign bus.o_report_strobe  = rpt_strobe_q;
    assign bus.o_global_maxsize = maxsize_q;
    assign bus.o_busy           = (state_q != S_IDLE) || rpt_valid_q;
endmodule

// File: tb/tb_clique_report_arbiter.sv
// Directed bench for clique_report_arbiter: cycle table plus hand-written corner sequences.
`ifndef MAX_CLIQUESIZEBITS
`define MAX_CLIQUESIZEBITS 8
`endif

module tb_clique_report_arbiter;
    localparam int NR = 4;
    localparam int SB = `MAX_CLIQUESIZEBITS;

    logic clk;
    logic rst_n;
    logic sreset;
    int   total;
    int   bad;

    clique_report_arbiter_if #(.NUM_REQ(NR), .SRC_BITS(2)) bus ();

    clique_report_arbiter #(.NUM_REQ(NR), .SRC_BITS(2)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_sreset  (sreset),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [15:0] w;
        logic        racc;
        logic [3:0]  eacc;
        logic        eov;
        logic [15:0] ev;
        logic [1:0]  esrc;
        logic        ebusy;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] lst, input logic [15:0] w,
                                input logic racc, input logic [3:0] eacc, input logic eov,
                                input logic [15:0] ev, input logic [1:0] esrc, input logic ebusy);
        vec_t r;
        r.vld = vld; r.lst = lst; r.w = w; r.racc = racc; r.eacc = eacc;
        r.eov = eov; r.ev = ev; r.esrc = esrc; r.ebusy = ebusy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int k, input logic vld, input logic lst, input logic [15:0] w,
                         input logic [SB-1:0] sz);
        bus.i_req_valid[k]          = vld;
        bus.i_req_strobe[k]         = vld;
        bus.i_req_last[k]           = lst;
        bus.i_req_v[k*16 +: 16]     = w;
        bus.i_req_size[k*SB +: SB]  = sz;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int k = 0; k < NR; k++) drive(k, 1'b0, 1'b0, 16'h0, '0);
        bus.i_report_accept = 1'b1;
        sreset = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Req1 3-word burst, then req2 3-word burst with 5-cycle downstream stall.
        tbl[0]  = mk(4'b0010, 4'b0000, 16'hA001, 1'b1, 4'b0000, 1'b0, 16'h0,    2'd0, 1'b0);
        tbl[1]  = mk(4'b0010, 4'b0000, 16'hA001, 1'b1, 4'b0010, 1'b0, 16'h0,    2'd0, 1'b1);
        tbl[2]  = mk(4'b0010, 4'b0000, 16'hA002, 1'b1, 4'b0010, 1'b1, 16'hA001, 2'd1, 1'b1);
        tbl[3]  = mk(4'b0010, 4'b0010, 16'hA003, 1'b1, 4'b0010, 1'b1, 16'hA002, 2'd1, 1'b1);
        tbl[4]  = mk(4'b0000, 4'b0000, 16'h0,    1'b1, 4'b0000, 1'b1, 16'hA003, 2'd1, 1'b1);
        tbl[5]  = mk(4'b0000, 4'b0000, 16'h0,    1'b1, 4'b0000, 1'b0, 16'h0,    2'd0, 1'b0);
        tbl[6]  = mk(4'b0100, 4'b0000, 16'hB001, 1'b1, 4'b0000, 1'b0, 16'h0,    2'd0, 1'b0);
        tbl[7]  = mk(4'b0100, 4'b0000, 16'hB001, 1'b1, 4'b0100, 1'b0, 16'h0,    2'd0, 1'b1);
        for (int i = 8; i <= 12; i++)
            tbl[i] = mk(4'b0100, 4'b0000, 16'hB002, 1'b0, 4'b0000, 1'b1, 16'hB001, 2'd2, 1'b1);
        tbl[13] = mk(4'b0100, 4'b0000, 16'hB002, 1'b1, 4'b0100, 1'b1, 16'hB001, 2'd2, 1'b1);
        tbl[14] = mk(4'b0100, 4'b0100, 16'hB003, 1'b1, 4'b0100, 1'b1, 16'hB002, 2'd2, 1'b1);
        tbl[15] = mk(4'b0000, 4'b0000, 16'h0,    1'b1, 4'b0000, 1'b1, 16'hB003, 2'd2, 1'b1);
        tbl[16] = mk(4'b0000, 4'b0000, 16'h0,    1'b1, 4'b0000, 1'b0, 16'h0,    2'd0, 1'b0);

        do_reset();
        #1;
        chk("rst_valid",   32'(bus.o_report_valid),   0);
        chk("rst_strobe",  32'(bus.o_report_strobe),  0);
        chk("rst_v",       32'(bus.o_report_v),       0);
        chk("rst_size",    32'(bus.o_report_size),    0);
        chk("rst_src",     32'(bus.o_report_src),     0);
        chk("rst_max",     32'(bus.o_global_maxsize), 0);
        chk("rst_dropped", 32'(bus.o_dropped),        0);
        chk("rst_busy",    32'(bus.o_busy),           0);
        chk("rst_acc",     32'(bus.o_req_accept),     0);
        tick();

        for (int i = 0; i < 17; i++) begin
            for (int k = 0; k < NR; k++) drive(k, tbl[i].vld[k], tbl[i].lst[k], tbl[i].w, '0);
            bus.i_report_accept = tbl[i].racc;
            #1;
            chk($sformatf("t%0d_acc", i),    32'(bus.o_req_accept),    32'(tbl[i].eacc));
            chk($sformatf("t%0d_valid", i),  32'(bus.o_report_valid),  32'(tbl[i].eov));
            chk($sformatf("t%0d_strobe", i), 32'(bus.o_report_strobe), 32'(tbl[i].eov));
            chk($sformatf("t%0d_busy", i),   32'(bus.o_busy),          32'(tbl[i].ebusy));
            if (tbl[i].eov) begin
                chk($sformatf("t%0d_v", i),   32'(bus.o_report_v),   32'(tbl[i].ev));
                chk($sformatf("t%0d_src", i), 32'(bus.o_report_src), 32'(tbl[i].esrc));
            end
            tick();
        end

        // Fairness: req0 first, req2 completes before req0 is regranted.
        do_reset();
        drive(0, 1'b1, 1'b1, 16'h0C00, '0);
        drive(2, 1'b1, 1'b0, 16'h0C20, '0);
        #1; chk("rr_c0_acc", 32'(bus.o_req_accept), 0); tick();
        #1; chk("rr_req0_first", 32'(bus.o_req_accept), 32'b0001); tick();
        #1; chk("rr_c2_acc", 32'(bus.o_req_accept), 0);
            chk("rr_c2_src", 32'(bus.o_report_src), 0); tick();
        #1; chk("rr_req2_second", 32'(bus.o_req_accept), 32'b0100);
            chk("rr_c3_valid", 32'(bus.o_report_valid), 0); tick();
        drive(2, 1'b1, 1'b1, 16'h0C21, '0);
        #1; chk("rr_req2_last", 32'(bus.o_req_accept), 32'b0100);
            chk("rr_c4_src", 32'(bus.o_report_src), 2); tick();
        drive(2, 1'b0, 1'b0, 16'h0, '0);
        #1; chk("rr_c5_acc", 32'(bus.o_req_accept), 0);
            chk("rr_c5_v", 32'(bus.o_report_v), 32'h0C21); tick();
        #1; chk("rr_req0_again", 32'(bus.o_req_accept), 32'b0001); tick();
        drive(0, 1'b0, 1'b0, 16'h0, '0);

        // Global max size tracking and sync clear.
        do_reset();
        drive(1, 1'b1, 1'b1, 16'h0D01, SB'(5));
        #1; tick();
        #1; chk("max_acc1", 32'(bus.o_req_accept), 32'b0010); tick();
        drive(1, 1'b0, 1'b0, 16'h0, '0);
        drive(3, 1'b1, 1'b1, 16'h0D03, SB'(3));
        #1; chk("max_after_5", 32'(bus.o_global_maxsize), 5); tick();
        #1; chk("max_acc3", 32'(bus.o_req_accept), 32'b1000); tick();
        drive(3, 1'b0, 1'b0, 16'h0, '0);
        #1; chk("max_stays_5", 32'(bus.o_global_maxsize), 5);
            chk("max_out_size3", 32'(bus.o_report_size), 3);
        sreset = 1'b1; tick();
        sreset = 1'b0;
        #1; chk("max_sreset", 32'(bus.o_global_maxsize), 0);
            chk("dropped_sreset", 32'(bus.o_dropped), 0);

        // Small burst after a larger one: dropped with the filter, forwarded without.
        do_reset();
        drive(0, 1'b1, 1'b1, 16'h0E00, SB'(6));
        #1; tick();
        #1; tick();
        drive(0, 1'b0, 1'b0, 16'h0, '0);
        drive(3, 1'b1, 1'b0, 16'h0E31, SB'(4));
        #1; chk("flt_max6", 32'(bus.o_global_maxsize), 6); tick();
        #1; chk("flt_w1_acc", 32'(bus.o_req_accept), 32'b1000);
            chk("flt_w1_valid", 32'(bus.o_report_valid), 0); tick();
        drive(3, 1'b1, 1'b0, 16'h0E32, SB'(4));
        #1; chk("flt_w2_acc", 32'(bus.o_req_accept), 32'b1000);
`ifdef CLIQUE_ARB_FILTER_EN
            chk("flt_w2_valid", 32'(bus.o_report_valid), 0);
`else
            chk("flt_w2_valid", 32'(bus.o_report_valid), 1);
            chk("flt_w2_v", 32'(bus.o_report_v), 32'h0E31);
            chk("flt_w2_src", 32'(bus.o_report_src), 3);
`endif
        tick();
        drive(3, 1'b1, 1'b1, 16'h0E33, SB'(4));
        #1; chk("flt_w3_acc", 32'(bus.o_req_accept), 32'b1000); tick();
        drive(3, 1'b0, 1'b0, 16'h0, '0);
        #1;
`ifdef CLIQUE_ARB_FILTER_EN
        chk("flt_end_valid", 32'(bus.o_report_valid), 0);
        chk("flt_dropped", 32'(bus.o_dropped), 1);
`else
        chk("flt_end_valid", 32'(bus.o_report_valid), 1);
        chk("flt_end_v", 32'(bus.o_report_v), 32'h0E33);
        chk("flt_dropped", 32'(bus.o_dropped), 0);
`endif
        chk("flt_max_keep", 32'(bus.o_global_maxsize), 6);
        tick();

        // Async reset in the middle of a req1 burst.
        do_reset();
        drive(0, 1'b1, 1'b1, 16'h0F00, '0);
        #1; tick();
        #1; chk("mid_req0_acc", 32'(bus.o_req_accept), 32'b0001); tick();
        drive(0, 1'b0, 1'b0, 16'h0, '0);
        drive(1, 1'b1, 1'b0, 16'h0F01, SB'(2));
        #1; tick();
        #1; chk("mid_req1_acc", 32'(bus.o_req_accept), 32'b0010); tick();
        drive(1, 1'b1, 1'b0, 16'h0F02, SB'(2));
        #1; chk("mid_pre_valid", 32'(bus.o_report_valid), 1);
            chk("mid_pre_v", 32'(bus.o_report_v), 32'h0F01);
        rst_n = 1'b0;
        #1; chk("mid_rst_valid", 32'(bus.o_report_valid), 0);
            chk("mid_rst_v", 32'(bus.o_report_v), 0);
            chk("mid_rst_size", 32'(bus.o_report_size), 0);
            chk("mid_rst_busy", 32'(bus.o_busy), 0);
            chk("mid_rst_acc", 32'(bus.o_req_accept), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b1, 16'h0F10, '0);
        #1; chk("post_idle_valid", 32'(bus.o_report_valid), 0);
            chk("post_idle_acc", 32'(bus.o_req_accept), 0); tick();
        #1; chk("post_req0_acc", 32'(bus.o_req_accept), 32'b0001);
            chk("post_no_partial", 32'(bus.o_report_valid), 0); tick();
        #1; chk("post_word_v", 32'(bus.o_report_v), 32'h0F10);
            chk("post_word_src", 32'(bus.o_report_src), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clique_report_arbiter.md
CLIQUE_REPORT_ARBITER -- requirements
Module: clique_report_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of clique_stack report requesters (2..8).
REQ-002 SHALL have parameter SRC_BITS, default 2, width of the source index (clog2 NUM_REQ).
REQ-003 SHALL have port i_clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port i_reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_sreset  in  1  synchronous clear of global maxsize and drop counter.
REQ-006 SHALL have port i_req_v  in  NUM_REQ*16  per-requester report word, slice k = requester k.
REQ-007 SHALL have port i_req_size  in  NUM_REQ*`MAX_CLIQUESIZEBITS  per-requester clique size.
REQ-008 SHALL have ports i_req_valid, i_req_strobe, i_req_last  in  NUM_REQ each  word valid, stack strobe, final word of burst.
REQ-009 SHALL have port o_req_accept  out  NUM_REQ  per-requester word consumed this cycle.
REQ-010 SHALL have ports o_report_v (16), o_report_size (`MAX_CLIQUESIZEBITS), o_report_src (SRC_BITS), o_report_valid, o_report_strobe  out  merged registered report stream.
REQ-011 SHALL have port i_report_accept  in  1  downstream consumes output word.
REQ-012 SHALL have port o_global_maxsize  out  `MAX_CLIQUESIZEBITS  largest size of any forwarded completed burst.
REQ-013 SHALL have ports o_busy (1) and o_dropped (8)  out  grant held; saturating dropped-burst count.

Function
REQ-014 SHALL implement states S_IDLE and S_GRANT, plus S_DROP when CLIQUE_ARB_FILTER_EN is defined.
REQ-015 In S_IDLE, SHALL grant the first requester with i_req_valid=1 searching round-robin from rr_ptr+1 mod NUM_REQ, latch grant index, enter S_GRANT next cycle; no word accepted in the grant cycle.
REQ-016 SHALL define out_load = !o_report_valid || i_report_accept; output registers load only when out_load=1.
REQ-017 In S_GRANT, SHALL assert o_req_accept[g] = i_req_valid[g] && out_load, and load that word, size, strobe and g into output registers (latency 1 cycle).
REQ-018 SHALL clear o_report_valid on out_load when no word is loaded that cycle.
REQ-019 On an accepted word with i_req_last[g]=1, SHALL set rr_ptr<=g and return to S_IDLE; grant never changes mid-burst.
REQ-020 SHALL never assert o_req_accept for a non-granted requester; at most one bit set per cycle.
REQ-021 SHALL update o_global_maxsize<=word size when a last word is loaded and its size exceeds current value (unsigned compare).
REQ-022 i_sreset SHALL clear o_global_maxsize and o_dropped, overriding a same-cycle update, without disturbing the FSM or stream.
REQ-023 o_busy SHALL equal (state != S_IDLE) || o_report_valid.
REQ-024 Requester deasserting i_req_valid mid-burst SHALL stall the grant (no timeout); output drains normally.

Reset
REQ-025 On i_reset_n=0, SHALL asynchronously set state=S_IDLE, rr_ptr=NUM_REQ-1, o_report_valid=0, o_report_strobe=0, o_report_v=0, o_report_size=0, o_report_src=0, o_global_maxsize=0, o_dropped=0, o_req_accept=0.
REQ-026 Reset mid-burst SHALL abandon the burst; no partial word SHALL appear after deassertion.

Configuration
REQ-027 Macro CLIQUE_ARB_FILTER_EN: when defined, on grant SHALL enter S_DROP instead of S_GRANT if the granted i_req_size < o_global_maxsize; S_DROP asserts o_req_accept[g]=i_req_valid[g] regardless of out_load, forwards nothing, and on last word increments o_dropped (saturating at 255), sets rr_ptr, returns to S_IDLE.
REQ-028 Without CLIQUE_ARB_FILTER_EN, every burst SHALL be forwarded and o_dropped SHALL be constant 0.

Verification
REQ-029 Req1 sends 3-word burst (last on word 3), accept held 1 -> o_report_src=1, words out on cycles grant+2..grant+4, o_req_accept[1] three cycles, FSM back in S_IDLE.
REQ-030 Req0 and req2 both valid from reset -> req0 granted first, req2 second; then req0 again valid -> req2 burst completes before req0 regranted.
REQ-031 i_report_accept=0 for 5 cycles mid-burst -> o_report_v/o_report_valid stable, o_req_accept=0 throughout, no word lost or duplicated.
REQ-032 Bursts size 5 then size 3 -> o_global_maxsize 5 after first last word, stays 5; i_sreset pulse -> 0.
REQ-033 FILTER_EN, global max 6, req3 burst size 4 -> all words accepted, o_report_valid stays 0, o_dropped=1; without macro same stimulus forwarded.
REQ-034 i_reset_n low during word 2 of 4-word burst -> outputs at reset values; next grant starts from requester 0.
